// File: rtl/var_16_1_to_3.sv
// Serial-to-parallel framer: collects a 3-word signed stream into OUT1..OUT3.
// Word 1 is marked by in_sof. Framing violations and idle timeouts are flagged
// on frame_err. Completed frames are published atomically with a one-cycle
// out_valid pulse.
module var_16_1_to_3 #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] in,
  input  logic               in_valid,
  input  logic               in_sof,
  output logic signed [15:0] out1,
  output logic signed [15:0] out2,
  output logic signed [15:0] out3,
  output logic               out_valid,
  output logic               frame_err
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       cnt;
  logic signed [DW-1:0] sh1;
  logic signed [DW-1:0] sh2;

  logic timeout_c;
  logic ld_sh1_c;
  logic ld_sh2_c;
  logic ld_out_c;
  logic err_c;

  // An idle cycle that would bring the counter up to TIMEOUT aborts the frame;
  // a valid word on that same cycle wins because in_valid masks the abort.
  assign timeout_c = (state != IDLE) && !in_valid && (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid && in_sof) state_nxt = GOT1;
      end
      GOT1: begin
        if (in_valid)       state_nxt = in_sof ? GOT1 : GOT2;
        else if (timeout_c) state_nxt = IDLE;
      end
      GOT2: begin
        if (in_valid)       state_nxt = in_sof ? GOT1 : IDLE;
        else if (timeout_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: register load enables and the error condition
  always_comb begin
    ld_sh1_c = 1'b0;
    ld_sh2_c = 1'b0;
    ld_out_c = 1'b0;
    err_c    = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        ld_sh1_c = 1'b1;
        err_c    = (state != IDLE);
      end else begin
        ld_sh2_c = (state == GOT1);
        ld_out_c = (state == GOT2);
        err_c    = (state == IDLE);
      end
    end else begin
      err_c = timeout_c;
    end
  end

  // Idle-cycle counter: cleared by any accepted word, saturates at TIMEOUT
  always_ff @(posedge clk) begin
    if (!rst_n)                                  cnt <= '0;
    else if (in_valid)                           cnt <= '0;
    else if (state != IDLE && cnt != CNT_MAX)    cnt <= cnt + CW'(1);
  end

  // Shadow registers, atomic output load and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh1       <= '0;
      sh2       <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ld_sh1_c) sh1 <= in;
      if (ld_sh2_c) sh2 <= in;
      if (ld_out_c) begin
        out1 <= sh1;
        out2 <= sh2;
        out3 <= in;
      end
      out_valid <= ld_out_c;
      frame_err <= err_c;
    end
  end

endmodule

// File: tb/tb_var_16_1_to_3.sv
// Bench for var_16_1_to_3: directed scenarios followed by random traffic,
// every cycle compared against a frame-level reference model.
module tb_var_16_1_to_3;

  localparam int unsigned TO = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] in;
  logic               in_valid;
  logic               in_sof;
  logic signed [15:0] out1;
  logic signed [15:0] out2;
  logic signed [15:0] out3;
  logic               out_valid;
  logic               frame_err;

  var_16_1_to_3 #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Reference model: words collected so far in the current frame
  logic signed [15:0] part [3];
  int                 plen;
  int                 idle;
  logic signed [15:0] e1, e2, e3;
  logic               e_ov, e_err;

  int total  = 0;
  int passed = 0;
  int n_ov   = 0;
  int n_err  = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model(input logic r, input logic v, input logic s, input logic signed [15:0] d);
    e_ov  = 1'b0;
    e_err = 1'b0;
    if (!r) begin
      plen = 0; idle = 0;
      e1 = '0; e2 = '0; e3 = '0;
    end else if (v) begin
      idle = 0;
      if (s) begin
        if (plen > 0) e_err = 1'b1;
        part[0] = d;
        plen = 1;
      end else if (plen == 0) begin
        e_err = 1'b1;
      end else begin
        part[plen] = d;
        plen++;
        if (plen == 3) begin
          e1 = part[0]; e2 = part[1]; e3 = part[2];
          e_ov = 1'b1;
          plen = 0;
        end
      end
    end else if (plen > 0) begin
      idle++;
      if (idle == int'(TO)) begin
        e_err = 1'b1;
        plen  = 0;
        idle  = 0;
      end
    end
  endtask

  // One clock: drive, step model on the edge, compare shortly after it
  task automatic step(input logic r, input logic v, input logic s, input logic signed [15:0] d);
    rst_n = r; in_valid = v; in_sof = s; in = d;
    @(posedge clk);
    model(r, v, s, d);
    #1;
    if (out_valid) n_ov++;
    if (frame_err) n_err++;
    chk("out1", out1, e1);
    chk("out2", out2, e2);
    chk("out3", out3, e3);
    chk("out_valid", {15'b0, out_valid}, {15'b0, e_ov});
    chk("frame_err", {15'b0, frame_err}, {15'b0, e_err});
    chk("ov_err_excl", {15'b0, out_valid & frame_err}, 16'h0);
    #3;
  endtask

  initial begin
    int ov0, er0;
    logic v, s, r;
    logic signed [15:0] d;
    plen = 0; idle = 0; e1 = '0; e2 = '0; e3 = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in = '0;

    // Reset, with junk on the inputs that must be ignored
    step(0, 1, 1, 16'sh1234);
    step(0, 1, 0, 16'sh5678);
    step(0, 0, 0, 16'sh0);

    // Extreme values: 0x0001, 0xFFFF, 0x8000
    ov0 = n_ov; er0 = n_err;
    step(1, 1, 1, 16'sh0001);
    step(1, 1, 0, 16'shFFFF);
    step(1, 1, 0, 16'sh8000);
    chk("x_out1", out1, 16'h0001);
    chk("x_out2", out2, 16'hFFFF);
    chk("x_out3", out3, 16'h8000);
    step(1, 0, 0, 16'sh0);
    chk("x_ov_once", 16'(n_ov - ov0), 16'd1);
    chk("x_no_err", 16'(n_err - er0), 16'd0);

    // Back-to-back frames at full throughput
    ov0 = n_ov; er0 = n_err;
    step(1, 1, 1, 16'sd10);
    step(1, 1, 0, 16'sd20);
    step(1, 1, 0, 16'sd30);
    step(1, 1, 1, 16'sd40);
    step(1, 1, 0, 16'sd50);
    step(1, 1, 0, 16'sd60);
    chk("b2b_out", out2, 16'd50);
    step(1, 0, 0, 16'sh0);
    chk("b2b_ov", 16'(n_ov - ov0), 16'd2);
    chk("b2b_err", 16'(n_err - er0), 16'd0);

    // SOF in mid-frame restarts the frame
    step(1, 1, 1, 16'sd5);
    step(1, 1, 0, 16'sd6);
    step(1, 1, 1, 16'sd7);
    chk("resync_err", {15'b0, frame_err}, 16'd1);
    step(1, 1, 0, 16'sd8);
    step(1, 1, 0, 16'sd9);
    chk("resync_out1", out1, 16'd7);
    chk("resync_out3", out3, 16'd9);

    // Timeout after TO idle cycles, outputs kept, then orphan word errors
    step(1, 1, 1, 16'sd100);
    step(1, 0, 0, 16'sh0);
    step(1, 0, 0, 16'sh0);
    step(1, 0, 0, 16'sh0);
    step(1, 0, 0, 16'sh0);
    chk("to_err", {15'b0, frame_err}, 16'd1);
    chk("to_keep", out1, 16'd7);
    step(1, 1, 0, 16'sd101);
    chk("orphan_err", {15'b0, frame_err}, 16'd1);

    // Reset mid-frame, then a clean frame
    er0 = n_err;
    step(1, 1, 1, 16'sd77);
    step(1, 1, 0, 16'sd78);
    step(0, 1, 0, 16'sd79);
    chk("rst_out1", out1, 16'd0);
    step(1, 1, 1, 16'sd1);
    step(1, 1, 0, 16'sd2);
    step(1, 1, 0, 16'sd3);
    chk("rst_frame", out3, 16'd3);
    chk("rst_no_err", 16'(n_err - er0), 16'd0);

    // Word arriving exactly on the timeout cycle is accepted
    step(1, 1, 1, 16'sd11);
    step(1, 0, 0, 16'sh0);
    step(1, 0, 0, 16'sh0);
    step(1, 0, 0, 16'sh0);
    step(1, 1, 0, 16'sd12);
    chk("edge_no_err", {15'b0, frame_err}, 16'd0);
    step(1, 1, 0, 16'sd13);
    chk("edge_ov", {15'b0, out_valid}, 16'd1);
    chk("edge_out2", out2, 16'd12);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) >= 2);
      v = ($urandom_range(0, 99) < 60);
      s = (plen == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 1);
      case ($urandom_range(0, 7))
        0:       d = 16'sh8000;
        1:       d = 16'sh7FFF;
        default: d = 16'($urandom);
      endcase
      step(r, v, s, d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/var_16_1_to_3.md
VAR_16_1_TO_3 -- requirements
Module: var_16_1_to_3

Interface
REQ-001 Parameter TIMEOUT, default 1000, SHALL be the maximum number of idle cycles allowed between words of one frame before the frame is aborted.
REQ-002 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 RST_N  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 IN  input  16 (signed)  SHALL carry one word of the serial 3-word stream.
REQ-005 IN_VALID  input  1  SHALL qualify IN; a word is accepted on every CLK edge where IN_VALID=1.
REQ-006 IN_SOF  input  1  SHALL mark the accepted word as word 1 of a frame; ignored when IN_VALID=0.
REQ-007 OUT1, OUT2, OUT3  output  16 each (signed, registered)  SHALL hold words 1, 2, 3 of the last complete frame.
REQ-008 OUT_VALID  output  1  SHALL pulse high for one cycle when OUT1..OUT3 are updated.
REQ-009 FRAME_ERR  output  1  SHALL pulse high for one cycle on any framing violation.

Function
REQ-010 The block SHALL run a state machine with states IDLE, GOT1 and GOT2, plus two 16-bit shadow registers SH1 and SH2 and a timeout counter.
REQ-011 In IDLE, on IN_VALID=1 with IN_SOF=1: SH1<=IN, next state GOT1.
REQ-012 In IDLE, on IN_VALID=1 with IN_SOF=0: the word is discarded, FRAME_ERR pulses, state stays IDLE.
REQ-013 In GOT1, on IN_VALID=1 with IN_SOF=0: SH2<=IN, next state GOT2.
REQ-014 In GOT2, on IN_VALID=1 with IN_SOF=0: OUT1<=SH1, OUT2<=SH2, OUT3<=IN all on the same edge, OUT_VALID=1 in the following cycle only, next state IDLE.
REQ-015 Outputs SHALL update atomically: OUT1..OUT3 never show a mix of two frames and change only on the REQ-014 edge.
REQ-016 Latency SHALL be 1 cycle from accepting word 3 to OUT1..OUT3/OUT_VALID being visible.
REQ-017 In GOT1 or GOT2, on IN_VALID=1 with IN_SOF=1: FRAME_ERR pulses, the partial frame is dropped, SH1<=IN, next state GOT1.
REQ-018 The timeout counter SHALL clear on every accepted word and increment on every cycle in GOT1/GOT2 with IN_VALID=0, saturating at TIMEOUT.
REQ-019 When the counter reaches TIMEOUT in GOT1/GOT2: FRAME_ERR pulses, next state IDLE, OUT1..OUT3 are unchanged.
REQ-020 If the timeout and a valid word coincide on the same edge, the word SHALL take priority: it is accepted and the counter clears.
REQ-021 Words SHALL be passed bit-exact with no arithmetic, sign change or saturation; -32768 and 32767 are transferred unchanged.
REQ-022 Back-to-back frames with IN_VALID=1 every cycle SHALL be sustained at full throughput (one frame per 3 cycles).
REQ-023 OUT_VALID and FRAME_ERR SHALL never be high in the same cycle, except when the REQ-017 case coincides with completion, which cannot occur by construction.

Reset
REQ-024 On RST_N=0 at a CLK edge: state<=IDLE; SH1, SH2, counter, OUT1..OUT3 <=0; OUT_VALID, FRAME_ERR <=0.
REQ-025 Reset mid-frame SHALL discard the partial frame without a FRAME_ERR pulse.
REQ-026 Inputs SHALL be ignored while RST_N=0.
REQ-027 The first word accepted after release of reset SHALL be processed per REQ-011/REQ-012.

Verification
REQ-028 Frame 0x0001(SOF), 0xFFFF, 0x8000 on consecutive cycles -> 1 cycle later OUT1=1, OUT2=-1, OUT3=-32768, OUT_VALID pulses once.
REQ-029 Two back-to-back frames (10,20,30) then (40,50,60) -> OUT_VALID pulses 3 cycles apart with the correct triples; no FRAME_ERR.
REQ-030 Words 5(SOF), 6, 7(SOF), 8, 9 -> FRAME_ERR on the SOF of word 7; outputs become (7,8,9).
REQ-031 TIMEOUT=4: word 1(SOF), then 4 idle cycles -> FRAME_ERR, state IDLE, old outputs kept; a following non-SOF word -> FRAME_ERR.
REQ-032 RST_N=0 after word 2 of a frame, then a full frame (1,2,3) -> outputs 0 during reset, then (1,2,3); no FRAME_ERR.
REQ-033 Valid word arriving on the exact timeout cycle -> word accepted, frame completes normally.
